uart_rx: RTL

UART receiver that is the companion to the team's UART transmitter. It oversamples the asynchronous serial line on the system clock and detects the start bit. It samples each bit at mid-bit and returns the assembled byte with a one-cycle valid pulse. Frame (stop-bit) errors are flagged. It sits between the board RX pin and the user logic and uses the same frame format as the transmitter: 1 start bit, DATA_WIDTH bits LSB first, 1 stop bit.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sync2.sv | 26 ++
 rtl/uart_rx.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and the baud divisor helper.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b010,
        STOP   = 3'b011,
        PARITY = 3'b100
    } uart_state_e;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_e;
`endif

    // Clock cycles per serial bit; also used by the transmitter.
    function automatic int unsigned baud_count(input int unsigned clk_freq_mhz,
                                               input int unsigned baudrate);
        return (clk_freq_mhz * 32'd1_000_000) / baudrate;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous inputs; resets to all ones (idle line level).
module uart_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_WIDTH data bits LSB first, 1 stop, mid-bit sampling.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop (PARITY_ODD selects odd).
module uart_rx import uart_pkg::*; #(
    parameter int DATA_WIDTH   = 8,
    parameter int BAUDRATE     = 9600,
    parameter int CLK_FREQ_MHZ = 125
`ifdef UART_RX_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  rx_valid,
    output logic                  rx_busy,
    output logic                  frame_err,
    output logic                  parity_err
);

    localparam int unsigned BAUDRATE_COUNT = baud_count(CLK_FREQ_MHZ, BAUDRATE);
    localparam int unsigned HALF_COUNT     = BAUDRATE_COUNT / 2;
    localparam int          CW             = $clog2(BAUDRATE_COUNT) + 1;
    localparam int          BW             = $clog2(DATA_WIDTH + 1);

    uart_state_e           state_q, state_d;
    logic [CW-1:0]         baud_cnt_q, baud_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  stop_q, stop_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  rx_s;
    logic                  baud_tc;
`ifdef UART_RX_PARITY_EN
    logic                  par_bad_q, par_bad_d;
    logic                  parity_err_q, parity_err_d;
`endif

    uart_sync2 #(.WIDTH(1)) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (rx),
        .q_o  (rx_s)
    );

    // START waits half a bit to land mid-start; every later state waits a full bit.
    assign baud_tc = (state_q == START) ? (baud_cnt_q == CW'(HALF_COUNT - 1))
                                        : (baud_cnt_q == CW'(BAUDRATE_COUNT - 1));

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        stop_d      = stop_q;
        done_d      = 1'b0;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        // Result of the previous cycle's stop sample; frame error wins over parity error.
        if (done_q) begin
            if (!stop_q) begin
                frame_err_d = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            else if (par_bad_q) begin
                parity_err_d = 1'b1;
            end
`endif
            else begin
                rx_valid_d = 1'b1;
                data_d     = shift_q;
            end
        end

        case (state_q)
            IDLE: begin
                if (!rx_s) state_d = START;
            end
            START: begin
                if (baud_tc) state_d = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (baud_tc) begin
                    shift_d   = {rx_s, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_tc) begin
                    par_bad_d = rx_s ^ (^shift_q) ^ PARITY_ODD;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                // Back to IDLE at mid-stop so a back-to-back start edge is not missed.
                if (baud_tc) begin
                    stop_d  = rx_s;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_d != state_q) || (state_q == IDLE) || baud_tc)
            baud_cnt_d = '0;
        else
            baud_cnt_d = baud_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            stop_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            done_q      <= done_d;
            stop_q      <= stop_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data_o    = data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
